// File: rtl/conv_window_generator_if.sv
// Pixel-stream in / window-stream out bundle for conv_window_generator.
// The windowCount signal exists only when WINDOW_COUNT_EN is defined.
interface conv_window_generator_if #(
  parameter int bitwidth    = 8,
  parameter int filterWidth = 3
);
  logic [bitwidth-1:0]                                   pixelIn;
  logic                                                  pixelValid;
  logic                                                  pixelReady;
  logic [filterWidth-1:0][0:filterWidth-1][bitwidth-1:0] window;
  logic                                                  windowValid;
  logic                                                  windowReady;
  logic                                                  frameDone;

  // master feeds pixels and consumes windows; slave is the generator
`ifdef WINDOW_COUNT_EN
  logic [31:0] windowCount;
  modport master (output pixelIn, pixelValid, windowReady,
                  input  pixelReady, window, windowValid, frameDone, windowCount);
  modport slave  (input  pixelIn, pixelValid, windowReady,
                  output pixelReady, window, windowValid, frameDone, windowCount);
`else
  modport master (output pixelIn, pixelValid, windowReady,
                  input  pixelReady, window, windowValid, frameDone);
  modport slave  (input  pixelIn, pixelValid, windowReady,
                  output pixelReady, window, windowValid, frameDone);
`endif
endinterface

// File: rtl/conv_window_generator.sv
// Raster pixel stream to stride-1 filterWidth x filterWidth windows with valid/ready on both sides.
// Optional WINDOW_COUNT_EN adds a per-frame accepted-window counter (windowCount).
module conv_window_generator #(
  parameter int bitwidth    = 8,
  parameter int filterWidth = 3,
  parameter int imageWidth  = 28,
  parameter int imageHeight = 28
) (
  input  logic                    clock,
  input  logic                    reset_n,
  conv_window_generator_if.slave  bus
);
  localparam int COL_W   = (imageWidth  > 1) ? $clog2(imageWidth)  : 1;
  localparam int ROW_W   = (imageHeight > 1) ? $clog2(imageHeight) : 1;
  localparam int LB_ROWS = filterWidth - 1;

  typedef logic [bitwidth-1:0] pix_t;
  typedef enum logic [1:0] {FILL, STREAM, EMIT} state_t;

  state_t                                                state_q;
  logic [COL_W-1:0]                                      col_q, col_d;
  logic [ROW_W-1:0]                                      row_q, row_d;
  logic                                                  rdy_en_q, last_q, frame_done_q;
  logic [filterWidth-1:0][0:filterWidth-1][bitwidth-1:0] win_q;
  logic [filterWidth-1:0][bitwidth-1:0]                  new_col;
  pix_t                                                  lb_rd [LB_ROWS];
  logic win_valid, pixel_ready, pix_acc, win_acc;
  logic col_last, row_last, in_window, next_in_window, completes;

  assign win_valid      = (state_q == EMIT);
  assign pixel_ready    = rdy_en_q && (!win_valid || bus.windowReady);
  assign pix_acc        = bus.pixelValid && pixel_ready;
  assign win_acc        = win_valid && bus.windowReady;
  assign col_last       = (col_q == COL_W'(imageWidth - 1));
  assign row_last       = (row_q == ROW_W'(imageHeight - 1));
  assign in_window      = (row_q >= ROW_W'(filterWidth - 1)) && (col_q >= COL_W'(filterWidth - 1));
  assign next_in_window = (row_d >= ROW_W'(filterWidth - 1)) && (col_d >= COL_W'(filterWidth - 1));
  assign completes      = pix_acc && in_window;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (pix_acc) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Cascaded line buffers: buffer 0 holds the previous row, buffer k the row k+1 above.
  // Reads are registered at the next column address so the column is ready at accept time.
  for (genvar gi = 0; gi < LB_ROWS; gi++) begin : g_lb
    pix_t mem [imageWidth];
    pix_t rd_q;
    pix_t wr_data;
    if (gi == 0) begin : g_head
      assign wr_data = bus.pixelIn;
    end else begin : g_tail
      assign wr_data = lb_rd[gi-1];
    end
    always_ff @(posedge clock) begin
      if (pix_acc) mem[col_q] <= wr_data;
      rd_q <= mem[col_d];
    end
    assign lb_rd[gi]                = rd_q;
    assign new_col[LB_ROWS - 1 - gi] = rd_q;
  end
  assign new_col[filterWidth-1] = bus.pixelIn;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      win_q <= '0;
    end else if (pix_acc) begin
      for (int r = 0; r < filterWidth; r++)
        win_q[r] <= {win_q[r][1:filterWidth-1], new_col[r]};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= FILL;
      col_q        <= '0;
      row_q        <= '0;
      rdy_en_q     <= 1'b0;
      last_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      rdy_en_q     <= 1'b1;
      col_q        <= col_d;
      row_q        <= row_d;
      frame_done_q <= win_acc && last_q;
      if (completes) begin
        state_q <= EMIT;
        last_q  <= row_last && col_last;
      end else if (!win_valid || win_acc) begin
        state_q <= next_in_window ? STREAM : FILL;
        last_q  <= 1'b0;
      end
    end
  end

  assign bus.pixelReady  = pixel_ready;
  assign bus.window      = win_q;
  assign bus.windowValid = win_valid;
  assign bus.frameDone   = frame_done_q;

`ifdef WINDOW_COUNT_EN
  logic [31:0] win_count_q;
  // Holds the frame total during the frameDone cycle, then restarts.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)          win_count_q <= '0;
    else if (frame_done_q) win_count_q <= {31'd0, win_acc};
    else if (win_acc)      win_count_q <= win_count_q + 32'd1;
  end
  assign bus.windowCount = win_count_q;
`endif
endmodule

// File: tb/tb_conv_window_generator.sv
// Scoreboard bench for conv_window_generator on a 4x4 image with 3x3 windows.
// Expected windows come from a frame array model; a negedge monitor compares outputs.
module tb_conv_window_generator;
  localparam int BW = 8, FW = 3, IW = 4, IH = 4;
  localparam int WPF = (IW - FW + 1) * (IH - FW + 1);
  localparam int SUMS [4] = '{54, 63, 90, 99};

  typedef logic [FW-1:0][0:FW-1][BW-1:0] win_t;
  typedef struct {
    win_t win;
    bit   last;
    int   idx;
    bit   base1;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  conv_window_generator_if #(.bitwidth(BW), .filterWidth(FW)) bus ();

  conv_window_generator #(
    .bitwidth(BW), .filterWidth(FW), .imageWidth(IW), .imageHeight(IH)
  ) dut (
    .clock  (clk),
    .reset_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0, errors = 0;
  exp_t exp_q [$];
  int   img [IH][IW];
  int   m_row = 0, m_col = 0, m_widx = 0, m_wc = 0;
  bit   exp_fd = 0, prev_rstn = 0;
  int   fd_count = 0, win_seen = 0, frames_sent = 0, cur_base = 0;
  int   wr_mode = 0, hold_cnt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Monitor + scoreboard: checks this cycle's outputs, then snoops the pixel about to be accepted.
  always @(negedge clk) begin
    bit   rdy_en, m_ready, clr_cnt;
    int   sum;
    exp_t e;
    rdy_en    = rst_n && prev_rstn;
    prev_rstn = rst_n;
    if (!rst_n) begin
      check("reset_window_valid", 128'(bus.windowValid), 128'(0));
      check("reset_frame_done",   128'(bus.frameDone),   128'(0));
      check("reset_pixel_ready",  128'(bus.pixelReady),  128'(0));
      check("reset_window",       128'(bus.window),      128'(0));
`ifdef WINDOW_COUNT_EN
      check("reset_window_count", 128'(bus.windowCount), 128'(0));
`endif
      exp_q.delete();
      m_row = 0; m_col = 0; m_widx = 0; m_wc = 0; exp_fd = 0;
    end else begin
      m_ready = rdy_en && (exp_q.size() == 0 || bus.windowReady);
      check("frame_done",   128'(bus.frameDone),   128'(exp_fd));
      check("window_valid", 128'(bus.windowValid), 128'(exp_q.size() != 0));
      check("pixel_ready",  128'(bus.pixelReady),  128'(m_ready));
`ifdef WINDOW_COUNT_EN
      check("window_count", 128'(bus.windowCount), 128'(m_wc));
`endif
      if (bus.frameDone) fd_count++;
      clr_cnt = exp_fd;
      exp_fd  = 0;
      if (clr_cnt) m_wc = 0;
      if (bus.windowValid && exp_q.size() != 0) begin
        check("window", 128'(bus.window), 128'(exp_q[0].win));
        if (bus.windowReady) begin
          e = exp_q.pop_front();
          win_seen++;
          m_wc++;
          exp_fd = e.last;
          if (e.base1 && e.idx < 4) begin
            sum = 0;
            for (int r = 0; r < FW; r++)
              for (int c = 0; c < FW; c++) sum += int'(bus.window[r][c]);
            check("window_sum", 128'(sum), 128'(SUMS[e.idx]));
          end
        end
      end
      if (m_ready && bus.pixelValid) begin
        img[m_row][m_col] = int'(bus.pixelIn);
        if (m_row >= FW - 1 && m_col >= FW - 1) begin
          for (int r = 0; r < FW; r++)
            for (int c = 0; c < FW; c++)
              e.win[r][c] = BW'(img[m_row - (FW - 1) + r][m_col - (FW - 1) + c]);
          e.last  = (m_row == IH - 1) && (m_col == IW - 1);
          e.idx   = m_widx;
          e.base1 = (cur_base == 1);
          m_widx++;
          exp_q.push_back(e);
        end
        m_col++;
        if (m_col == IW) begin
          m_col = 0;
          m_row++;
          if (m_row == IH) begin m_row = 0; m_widx = 0; end
        end
      end
    end
  end

  // Downstream ready: 0 = always ready, 1 = hold 5 cycles per window, 2 = random.
  initial begin
    bus.windowReady = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (wr_mode)
        1: if (bus.windowValid && hold_cnt < 5) begin
             bus.windowReady = 1'b0;
             hold_cnt++;
           end else begin
             bus.windowReady = 1'b1;
             hold_cnt = 0;
           end
        2: bus.windowReady = 1'($urandom_range(1));
        default: bus.windowReady = 1'b1;
      endcase
    end
  end

  task automatic send_pixel(input logic [BW-1:0] v, input int gap_pct);
    int n;
    while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
      bus.pixelValid = 1'b0;
      @(posedge clk); #1;
    end
    bus.pixelIn    = v;
    bus.pixelValid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.pixelReady) break;
      n++;
      if (n > 100) begin
        checks++; errors++;
        $display("FAIL pixel_timeout: got no pixelReady, want pixelReady within 100 cycles");
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input int base, input int gap_pct, input bit rnd);
    cur_base = rnd ? 0 : base;
    for (int i = 0; i < IW * IH; i++)
      send_pixel(rnd ? BW'($urandom_range(255)) : BW'(base + i), gap_pct);
    bus.pixelValid = 1'b0;
    frames_sent++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending windows, want 0", exp_q.size());
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b1;
    bus.pixelIn    = '0;
    bus.pixelValid = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    wr_mode = 0; send_frame(1, 0, 0);  drain();
    wr_mode = 1; send_frame(1, 0, 0);  drain();
    wr_mode = 0; send_frame(1, 50, 0); drain();
    wr_mode = 0; send_frame(1, 0, 0);  send_frame(101, 0, 0); drain();

    cur_base = 1;
    for (int i = 1; i <= 7; i++) send_pixel(BW'(i), 0);
    bus.pixelValid = 1'b0;
    pulse_reset();
    send_frame(1, 0, 0); drain();

    wr_mode = 2;
    for (int f = 0; f < 3; f++) send_frame(0, 30, 1);
    drain();
    wr_mode = 1; send_frame(0, 20, 1); drain();

    check("frame_done_count", 128'(fd_count), 128'(frames_sent));
    check("window_total",     128'(win_seen), 128'(frames_sent * WPF));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_window_generator.md
Name: conv_window_generator

Overview:
- Producer side of the convolution adder tree. Accepts a raster-order pixel stream and emits every valid, stride-1 filterWidth x filterWidth window.
- Each window is presented as the addends array, with windowValid serving as the adder tree's canStartAdding.
- Sits between the image input stream and the adder tree. Row history is held in line buffers of (filterWidth-1) rows.
- A valid/ready handshake on both sides absorbs the adder tree's multi-cycle reduction time.

Parameters:
- bitwidth, 8, width of one pixel.
- filterWidth, 3, window edge length; legal range 2..8.
- imageWidth, 28, pixels per row; must be >= filterWidth.
- imageHeight, 28, rows per frame; must be >= filterWidth.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous reset, active-low.
- pixelIn  input  bitwidth  current pixel, raster order (row-major, top-left first).
- pixelValid  input  1  pixelIn is valid this cycle.
- pixelReady  output  1  block can accept a pixel this cycle.
- window  output  bitwidth x [filterWidth-1:0][0:filterWidth-1]  current window; window[r][c], r=0 is the top row, c=0 is the left column.
- windowValid  output  1  window is valid; drives the adder tree's canStartAdding.
- windowReady  input  1  downstream accepts the window this cycle.
- frameDone  output  1  one-cycle pulse when the last window of a frame is accepted.

Behaviour:
- Reset (reset_n low, asynchronous):
  - windowValid=0, frameDone=0, window all zeros, pixelReady=0.
  - Row and column counters cleared to 0.
  - Line buffer contents are don't-care; fill gating guarantees they are never emitted before being rewritten.
- After reset deasserts, pixelReady=1 from the first clock edge onward.
- Pixel accept: pixelValid && pixelReady at a rising edge.
- On accept:
  - Pixel is written into the line buffer and the window shift registers.
  - col increments. At col==imageWidth-1, col wraps to 0 and row increments.
  - At row==imageHeight-1 and col==imageWidth-1, both wrap to 0 and the next frame starts with fresh fill.
- Window emission: an accepted pixel at (row,col) with row>=filterWidth-1 and col>=filterWidth-1 completes a window.
  - The window is registered on the same edge, so windowValid=1 the following cycle (latency 1).
  - window[r][c] = pixel(row-(filterWidth-1)+r, col-(filterWidth-1)+c).
- Per frame: exactly (imageWidth-filterWidth+1)*(imageHeight-filterWidth+1) windows. No windows straddle row ends; no padding.
- Handshake:
  - window and windowValid stay stable while windowValid && !windowReady.
  - pixelReady = reset_n_synced && (!windowValid || windowReady).
  - Simultaneous window accept and pixel accept is legal and gives a full-rate window stream.
  - windowValid drops the cycle after accept unless the same-edge pixel completed a new window.
- States:
  - FILL: fewer than filterWidth-1 rows, or col<filterWidth-1; pixels absorbed, no window.
  - EMIT: windowValid=1 waiting for windowReady.
  - STREAM: idle between windows.
  - Transitions follow the counters above. HOLD is EMIT with windowReady=0.
- frameDone: asserted for one cycle on the cycle after the final window of a frame is accepted.
- pixelValid gaps: counters and buffers freeze, and no window is produced.
- Reset mid-frame: partial frame discarded, no frameDone. The next pixel is treated as (0,0).
- Counter widths: $clog2 of imageWidth and imageHeight. Pixel values pass through unmodified, with no arithmetic.

Optional Feature:
- Macro: WINDOW_COUNT_EN.
- Defined: adds output windowCount (32 bits, reset 0), which increments on every window accept and is cleared the cycle frameDone pulses. This lets the bench and debug check the per-frame window count.
- Undefined: port and counter absent. Behaviour is otherwise identical.

Test Plan:
- imageWidth=imageHeight=4, filterWidth=3, pixels 1..16 contiguous, windowReady=1 -> 4 windows with adder sums 54, 63, 90, 99. First windowValid is 1 cycle after pixel 11 is accepted. frameDone pulses once.
- Same stimulus, windowReady held 0 for 5 cycles after each windowValid -> pixelReady=0 while held, window stable, sums unchanged, no pixel lost or duplicated.
- Random pixelValid gaps (50% duty), same 16 pixels -> identical window sequence and frameDone count as the contiguous run.
- Two frames back-to-back, second frame pixels 101..116 -> second frame's first window [[101,102,103],[105,106,107],[109,110,111]]. No window mixes frames.
- reset_n pulsed low after pixel 7, then pixels 1..16 resent -> no window before reset completes. Output afterwards matches a clean frame (54, 63, 90, 99).
- WINDOW_COUNT_EN defined, 28x28 frame, filterWidth=3 -> windowCount reaches 676 before frameDone, then reads 0.
